// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and constants for the UDP TX request arbiter.
// FSM encoding, captured-register indices, default watchdog limit.
package udp_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARB       = 2'd1,
    S_LOAD      = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int REG_DIP     = 0;
  localparam int REG_PORTS   = 1;
  localparam int REG_PAYLOAD = 2;
  localparam int REG_LEN     = 3;

  localparam int TMO_CYC_DEF = 4096;

endpackage

// File: rtl/udp_tx_arbiter_rr.sv
// Combinational round-robin selector: search starts one past the
// previous winner and wraps modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [1:0]   i_last,
  output logic [N-1:0] o_gnt,
  output logic [1:0]   o_idx,
  output logic         o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = i_last;
    o_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!o_any && i_req[i] &&
            (i == (int'(i_last) + k) % N)) begin
          o_gnt[i] = 1'b1;
          o_idx    = 2'(i);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// UDP TX arbiter: grants one requester, hands its fields to the datapath.
// Optional WAIT_DONE watchdog with tmo_err output: UDP_ARB_TIMEOUT_EN.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_dest_ip,
  input  logic [NUM_REQ*32-1:0] req_ports,
  input  logic [NUM_REQ*32-1:0] req_payload,
  input  logic [NUM_REQ*32-1:0] req_len,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [31:0]           in_reg1,
  output logic [31:0]           in_reg2,
  output logic [31:0]           in_reg3,
  output logic [31:0]           in_reg4,
  output logic [3:0]            reg_loaded,
  input  logic [3:0]            reg_got,
  input  logic                  tlst,
  input  logic                  tvalid,
  input  logic                  s_axis_tready,
  output logic [1:0]            grant_id,
`ifdef UDP_ARB_TIMEOUT_EN
  output logic                  tmo_err,
`endif
  output logic                  busy
);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num
    $error("NUM_REQ must be 2..4");
  end
  if (TMO_CYC < 2 || TMO_CYC > 65535) begin : g_bad_tmo
    $error("TMO_CYC must fit the 16-bit watchdog");
  end

  localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [1:0]           r_grant;
  logic [1:0]           r_last;
  logic [1:0]           w_idx;
  logic                 w_any;
  logic [3:0]           r_loaded;
  logic [3:0]           w_loaded_nxt;
  logic [31:0]          r_reg [4];
  logic [31:0]          w_fld [4];
  logic                 w_beat_last;
  logic                 w_tmo_hit;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    for (int f = 0; f < 4; f++) w_fld[f] = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == 2'(i)) begin
        w_fld[REG_DIP]     = req_dest_ip[i*32 +: 32];
        w_fld[REG_PORTS]   = req_ports[i*32 +: 32];
        w_fld[REG_PAYLOAD] = req_payload[i*32 +: 32];
        w_fld[REG_LEN]     = req_len[i*32 +: 32];
      end
    end
  end

  assign w_beat_last  = tvalid & s_axis_tready & tlst;
  assign w_loaded_nxt = r_loaded & ~reg_got;

`ifdef UDP_ARB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_tmo_err;

  // A closing beat in the same cycle wins over the watchdog.
  assign w_tmo_hit = (r_state == S_WAIT_DONE) && !w_beat_last &&
                     (r_tmo_cnt == 16'(TMO_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo_hit;
      if (r_state == S_WAIT_DONE && !w_tmo_hit)
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      else
        r_tmo_cnt <= '0;
    end
  end

  assign tmo_err = r_tmo_err;
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (|req_valid) w_state_nxt = S_ARB;
      S_ARB:
        w_state_nxt = w_any ? S_LOAD : S_IDLE;
      S_LOAD:
        if (w_loaded_nxt == 4'b0000) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:
        if (w_beat_last || w_tmo_hit) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack    <= '0;
      r_grant  <= 2'd0;
      r_last   <= LAST_RST;
      r_loaded <= 4'b0000;
      for (int f = 0; f < 4; f++) r_reg[f] <= '0;
    end else begin
      r_ack <= '0;
      if (r_state == S_ARB && w_any) begin
        r_ack    <= w_gnt;
        r_grant  <= w_idx;
        r_last   <= w_idx;
        r_loaded <= 4'b1111;
        for (int f = 0; f < 4; f++) r_reg[f] <= w_fld[f];
      end else if (r_state == S_LOAD) begin
        r_loaded <= w_loaded_nxt;
      end else if (w_tmo_hit) begin
        r_loaded <= 4'b0000;
      end
    end
  end

  assign req_ack    = r_ack;
  assign grant_id   = r_grant;
  assign reg_loaded = r_loaded;
  assign in_reg1    = r_reg[REG_DIP];
  assign in_reg2    = r_reg[REG_PORTS];
  assign in_reg3    = r_reg[REG_PAYLOAD];
  assign in_reg4    = r_reg[REG_LEN];
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (NUM_REQ=2).
// Watchdog scenario runs when UDP_ARB_TIMEOUT_EN is defined.
module tb_udp_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_dest_ip, req_ports, req_payload, req_len;
  logic [1:0]  req_ack;
  logic [31:0] in_reg1, in_reg2, in_reg3, in_reg4;
  logic [3:0]  reg_loaded;
  logic [3:0]  reg_got;
  logic        tlst, tvalid, s_axis_tready;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef UDP_ARB_TIMEOUT_EN
  logic        tmo_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] got_seq [4] = '{4'h8, 4'h1, 4'h4, 4'h2};
  logic [3:0] ld_exp  [4] = '{4'h7, 4'h6, 4'h2, 4'h0};
  logic [1:0] gid_exp [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
  logic [1:0] ack_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  always #5 clk = ~clk;

  udp_tx_arbiter #(
    .NUM_REQ (2)
`ifdef UDP_ARB_TIMEOUT_EN
    , .TMO_CYC (16)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dest_ip   (req_dest_ip),
    .req_ports     (req_ports),
    .req_payload   (req_payload),
    .req_len       (req_len),
    .req_ack       (req_ack),
    .in_reg1       (in_reg1),
    .in_reg2       (in_reg2),
    .in_reg3       (in_reg3),
    .in_reg4       (in_reg4),
    .reg_loaded    (reg_loaded),
    .reg_got       (reg_got),
    .tlst          (tlst),
    .tvalid        (tvalid),
    .s_axis_tready (s_axis_tready),
    .grant_id      (grant_id),
`ifdef UDP_ARB_TIMEOUT_EN
    .tmo_err       (tmo_err),
`endif
    .busy          (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_fields();
    req_dest_ip = {32'h0A000002, 32'hC0A80001};
    req_ports   = {32'h00350035, 32'h1F902710};
    req_payload = {32'h22222222, 32'hDEADBEEF};
    req_len     = {32'd8, 32'd64};
  endtask

  task automatic wait_ack(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (req_ack != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_pkt();
    reg_got = 4'hF;
    step();
    reg_got = 4'h0;
    {tvalid, s_axis_tready, tlst} = 3'b111;
    step();
    {tvalid, s_axis_tready, tlst} = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    reg_got = 4'h0;
    {tvalid, s_axis_tready, tlst} = 3'b000;
    set_fields();
    repeat (2) step();
    n_vec++;
    if ({busy, req_ack, grant_id, reg_loaded} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0",
               {busy, req_ack, grant_id, reg_loaded});
    end
    n_vec++;
    if ({in_reg1, in_reg2, in_reg3, in_reg4} !== 128'd0) begin
      n_err++;
      $display("FAIL reset_regs: got %h want 0",
               {in_reg1, in_reg2, in_reg3, in_reg4});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 2'b01;
    step();
    n_vec++;
    if ({busy, req_ack} !== 3'b100) begin
      n_err++;
      $display("FAIL arb_cycle: got %b want 100", {busy, req_ack});
    end
    step();
    n_vec++;
    if (req_ack !== 2'b01 || grant_id !== 2'd0 || reg_loaded !== 4'hF) begin
      n_err++;
      $display("FAIL grant0: ack %b gid %0d ld %h want 01 0 f",
               req_ack, grant_id, reg_loaded);
    end
    n_vec++;
    if ({in_reg1, in_reg2, in_reg3, in_reg4} !==
        {32'hC0A80001, 32'h1F902710, 32'hDEADBEEF, 32'd64}) begin
      n_err++;
      $display("FAIL capture0: got %h %h %h %h want c0a80001 1f902710 deadbeef 40",
               in_reg1, in_reg2, in_reg3, in_reg4);
    end
    req_valid = 2'b00;
    req_dest_ip[31:0] = 32'h01010101;
    step();
    n_vec++;
    if (req_ack !== 2'b00 || in_reg1 !== 32'hC0A80001) begin
      n_err++;
      $display("FAIL hold: ack %b reg1 %h want 00 c0a80001", req_ack, in_reg1);
    end
  endtask

  task automatic test_load_order();
    for (int i = 0; i < 4; i++) begin
      reg_got = got_seq[i];
      {tvalid, s_axis_tready, tlst} = 3'b111;
      step();
      reg_got = 4'h0;
      n_vec++;
      if (reg_loaded !== ld_exp[i] || busy !== 1'b1) begin
        n_err++;
        $display("FAIL load_%0d: ld %h busy %b want %h 1",
                 i, reg_loaded, busy, ld_exp[i]);
      end
    end
    {tvalid, s_axis_tready, tlst} = 3'b101;
    step();
    {tvalid, s_axis_tready, tlst} = 3'b110;
    step();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL partial_beat: busy %b want 1", busy);
    end
    {tvalid, s_axis_tready, tlst} = 3'b111;
    step();
    {tvalid, s_axis_tready, tlst} = 3'b000;
    n_vec++;
    if (busy !== 1'b0 || in_reg1 !== 32'hC0A80001) begin
      n_err++;
      $display("FAIL done: busy %b reg1 %h want 0 c0a80001", busy, in_reg1);
    end
  endtask

  task automatic test_drop();
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    n_vec++;
    if ({busy, req_ack, reg_loaded} !== 7'd0) begin
      n_err++;
      $display("FAIL drop: got %b want 0", {busy, req_ack, reg_loaded});
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    do_reset();
    set_fields();
    req_valid = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_ack(seen);
      n_vec++;
      if (!seen || req_ack !== ack_exp[p] || grant_id !== gid_exp[p]) begin
        n_err++;
        $display("FAIL rr_%0d: ack %b gid %0d want %b %0d",
                 p, req_ack, grant_id, ack_exp[p], gid_exp[p]);
      end
      finish_pkt();
    end
    req_valid = 2'b10;
    wait_ack(seen);
    n_vec++;
    if (!seen || grant_id !== 2'd1 || in_reg1 !== 32'h0A000002) begin
      n_err++;
      $display("FAIL only_ch1: gid %0d reg1 %h want 1 0a000002",
               grant_id, in_reg1);
    end
    finish_pkt();
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    req_valid = 2'b11;
    wait_ack(seen);
    finish_pkt();
    wait_ack(seen);
    reg_got = 4'hF;
    step();
    reg_got = 4'h0;
    step();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, req_ack, grant_id, reg_loaded, in_reg1, in_reg4} !== 73'd0) begin
      n_err++;
      $display("FAIL rst_mid_wait: got %h want 0",
               {busy, req_ack, grant_id, reg_loaded, in_reg1, in_reg4});
    end
    step();
    rst = 1'b0;
    req_valid = 2'b11;
    wait_ack(seen);
    n_vec++;
    if (!seen || grant_id !== 2'd0 || req_ack !== 2'b01) begin
      n_err++;
      $display("FAIL post_rst_grant: gid %0d ack %b want 0 01",
               grant_id, req_ack);
    end
    finish_pkt();
    do_reset();
    req_valid = 2'b10;
    wait_ack(seen);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, req_ack, grant_id, reg_loaded, in_reg2} !== 41'd0) begin
      n_err++;
      $display("FAIL rst_mid_load: got %h want 0",
               {busy, req_ack, grant_id, reg_loaded, in_reg2});
    end
    step();
    rst = 1'b0;
    req_valid = 2'b00;
  endtask

`ifdef UDP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    do_reset();
    req_valid = 2'b01;
    wait_ack(seen);
    req_valid = 2'b00;
    reg_got = 4'hF;
    step();
    reg_got = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_vec++;
      if (tmo_err !== (k == 16)) begin
        n_err++;
        $display("FAIL tmo_cyc_%0d: tmo_err %b want %b", k, tmo_err, k == 16);
      end
    end
    step();
    n_vec++;
    if (busy !== 1'b0 || tmo_err !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_after: busy %b tmo %b want 0 0", busy, tmo_err);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_load_order();
    test_drop();
    test_back_to_back();
    test_reset_mid();
`ifdef UDP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of requester channels (2..4).
REQ-002 SHALL have parameter TMO_CYC, default 4096, meaning the WAIT_DONE watchdog limit in cycles (used only under REQ-026).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-channel packet request.
REQ-006 SHALL have port req_dest_ip, input, NUM_REQ*32 bits: per-channel destination IP.
REQ-007 SHALL have port req_ports, input, NUM_REQ*32 bits: per-channel {src_port, dest_port}.
REQ-008 SHALL have port req_payload, input, NUM_REQ*32 bits: per-channel payload word.
REQ-009 SHALL have port req_len, input, NUM_REQ*32 bits: per-channel payload length.
REQ-010 SHALL have port req_ack, output, NUM_REQ bits: one-cycle pulse when the granted channel's fields are captured.
REQ-011 SHALL have port in_reg1, in_reg2, in_reg3 and in_reg4, outputs, 32 bits each: captured IP, ports, payload and length driven to the datapath.
REQ-012 SHALL have port reg_loaded, output, 4 bits: per-register loaded flags (bit0 = reg1).
REQ-013 SHALL have port reg_got, input, 4 bits: per-register consumed acknowledges from the datapath.
REQ-014 SHALL have ports tlst, tvalid and s_axis_tready, inputs, 1 bit each: monitored datapath stream, where a beat is tvalid&s_axis_tready.
REQ-015 SHALL have port grant_id, output, 2 bits: the currently or last granted channel.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ARB -> LOAD -> WAIT_DONE -> IDLE.
REQ-018 In IDLE, SHALL move to ARB on the cycle after any req_valid bit is high.
REQ-019 In ARB, SHALL pick the winner by round-robin starting at (last_grant+1) mod NUM_REQ, capture its four fields into in_reg1..4, pulse req_ack[winner] for exactly one cycle, update grant_id and last_grant, set reg_loaded=4'b1111, and go to LOAD. Arbitration plus capture SHALL take exactly 1 cycle.
REQ-020 In LOAD, each reg_loaded[i] SHALL clear on the cycle after reg_got[i] is seen high; got bits may arrive in any order or simultaneously. On the cycle all four have been seen, SHALL go to WAIT_DONE.
REQ-021 In WAIT_DONE, SHALL return to IDLE on the cycle after a beat with tlst=1; this is the earliest point at which a new grant can occur.
REQ-022 in_reg1..4 SHALL hold stable from capture until the next ARB; requester inputs changing outside ARB SHALL have no effect.
REQ-023 A req_valid that drops before ARB SHALL cause no grant; if all req_valid bits are low in ARB, SHALL return to IDLE without a pulse.
REQ-024 With all channels continuously requesting, grants SHALL rotate 0,1,..,NUM_REQ-1,0 with no channel granted twice before every other channel is granted once.

Reset
REQ-025 On rst assertion, at any state including mid-LOAD or mid-WAIT_DONE, SHALL asynchronously force: state IDLE, in_reg1..4=0, reg_loaded=0, req_ack=0, grant_id=0, busy=0, last_grant=NUM_REQ-1 (so that channel 0 wins first), timeout counter=0.

Configuration
REQ-026 With UDP_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL run in WAIT_DONE and on reaching TMO_CYC SHALL force IDLE, pulse output tmo_err (1 bit, reset 0) for one cycle, and clear reg_loaded.
REQ-027 Without UDP_ARB_TIMEOUT_EN, the tmo_err port and the counter SHALL be absent, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=0, ARB=1, LOAD=2, WAIT_DONE=3), the register-index constants REG_DIP/REG_PORTS/REG_PAYLOAD/REG_LEN, and the default TMO_CYC.
REQ-029 The round-robin selector SHALL be one sub-module, rr_arbiter (request vector plus last grant in, one-hot grant plus index out, combinational).

Verification
REQ-030 With reset released and req_valid=2'b01, dest_ip=32'hC0A80001 on ch0: req_ack=2'b01 within 2 cycles, in_reg1=C0A80001, reg_loaded=4'hF.
REQ-031 During LOAD, reg_got pulses in order 8,1,4,2: reg_loaded bits clear one by one and the FSM reaches WAIT_DONE only after the fourth; then tvalid=tready=tlst=1 for one beat returns busy=0 the next cycle.
REQ-032 With req_valid=2'b11 held for 4 packets: grant_id sequence is 0,1,0,1.
REQ-033 rst asserted mid-WAIT_DONE: all outputs read 0 in the same cycle, and the next grant goes to ch0.
REQ-034 With UDP_ARB_TIMEOUT_EN defined and TMO_CYC=16, no tlst after LOAD: tmo_err pulses exactly 16 cycles after entering WAIT_DONE and busy=0 on the following cycle.
